// File: rtl/ieee_fpu_pkg.sv
// Shared definitions for the IEEE-754 single-precision divider:
// field widths, special constants, exception flag positions, FSM states
// and the unpacked-operand view used by the divider datapath.
package ieee_fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;

    // exc_flags = {invalid, div_by_zero, overflow, underflow}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_DIV_ZERO  = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM,
        S_ROUND
    } div_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } fp_unpack_t;

    // Denormals (exp == 0) are classified as zero: they are flushed.
    function automatic fp_unpack_t fp_unpack(input logic [31:0] x);
        fp_unpack_t u;
        u.sign    = x[31];
        u.exp     = x[FRAC_W +: EXP_W];
        u.frac    = x[FRAC_W-1:0];
        u.is_zero = (u.exp == '0);
        u.is_inf  = (u.exp == '1) && (u.frac == '0);
        u.is_nan  = (u.exp == '1) && (u.frac != '0);
        return u;
    endfunction

endpackage

// File: rtl/ieee_fpu_mant_div.sv
// One restoring radix-2 division step on 24-bit mantissas.
// The partial remainder always stays below twice the divisor, so the
// shifted result fits the 25-bit remainder width.
module ieee_fpu_mant_div (
    input  logic [24:0] rem,
    input  logic [23:0] divisor,
    output logic        q_bit,
    output logic [24:0] next_rem
);

    logic [24:0] sel;

    // Compare, conditionally subtract, then shift for the next bit.
    always_comb begin
        q_bit    = (rem >= {1'b0, divisor});
        sel      = q_bit ? (rem - {1'b0, divisor}) : rem;
        next_rem = sel << 1;
    end

endmodule

// File: rtl/ieee_fpu_div.sv
// Multi-cycle IEEE-754 single-precision divider, result = a_in / b_in.
// Start/ready pulse handshake; denormal inputs flushed to zero.
// Build option: FPU_DIV_RNE_EN selects round-to-nearest-even; when it is
// not defined the quotient is truncated toward zero (same latency).
module ieee_fpu_div
    import ieee_fpu_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        ready_out,
    output logic [31:0] result,
    output logic [3:0]  exc_flags
);

    div_state_t        state;
    logic [31:0]       a_r, b_r;
    fp_unpack_t        ua, ub;
    logic              sign_c;
    logic signed [9:0] exp_calc, exp_r, exp_fin;
    logic [24:0]       rem_r, next_rem;
    logic              q_bit;
    logic [QBITS-1:0]  q_r;
    logic [7:0]        cnt;
    logic [23:0]       mant_r, norm_mant;
    logic              special_r, is_special;
    logic [31:0]       spec_result, rnd_result;
    logic [3:0]        spec_flags, rnd_flags;
    logic              round_up;
    logic [24:0]       mant_inc;
    logic [22:0]       frac_fin;

    // Operand classification and unbiased-difference exponent.
    always_comb begin
        ua       = fp_unpack(a_r);
        ub       = fp_unpack(b_r);
        sign_c   = ua.sign ^ ub.sign;
        exp_calc = 10'(ua.exp) - 10'(ub.exp) + 10'(BIAS);
    end

    ieee_fpu_mant_div u_mant_div (
        .rem      (rem_r),
        .divisor  ({1'b1, ub.frac}),
        .q_bit    (q_bit),
        .next_rem (next_rem)
    );

    // Special-operand results in priority order.
    always_comb begin
        is_special  = 1'b1;
        spec_result = '0;
        spec_flags  = '0;
        if (ua.is_nan || ub.is_nan) begin
            spec_result = QNAN;
        end else if ((ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
            spec_result = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (ub.is_zero && !ua.is_inf) begin
            spec_result = INF | {sign_c, 31'd0};
            spec_flags[FLAG_DIV_ZERO] = 1'b1;
        end else if (ua.is_inf) begin
            spec_result = INF | {sign_c, 31'd0};
        end else if (ua.is_zero || ub.is_inf) begin
            spec_result = {sign_c, 31'd0};
        end else begin
            is_special = 1'b0;
        end
    end

`ifdef FPU_DIV_RNE_EN
    logic [QBITS-1:0] q_norm;
    logic             guard_r, sticky_r;

    // Normalised quotient: leading one moved to the top bit.
    always_comb begin
        q_norm    = q_r[QBITS-1] ? q_r : (q_r << 1);
        norm_mant = q_norm[QBITS-1 -: 24];
    end

    // Capture guard and sticky (dropped bits plus nonzero remainder).
    always_ff @(posedge clk) begin
        if (rst) begin
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
        end else if (state == S_NORM) begin
            guard_r  <= q_norm[QBITS-25];
            sticky_r <= (|q_norm[QBITS-26:0]) | (|rem_r);
        end
    end
`else
    // Normalised 24-bit mantissa; lower bits are discarded by truncation.
    always_comb begin
        norm_mant = q_r[QBITS-1] ? q_r[QBITS-1 -: 24] : q_r[QBITS-2 -: 24];
    end
`endif

    // Round, renormalise on carry-out, then range-check and pack.
    always_comb begin
`ifdef FPU_DIV_RNE_EN
        round_up = guard_r & (sticky_r | mant_r[0]);
`else
        round_up = 1'b0;
`endif
        mant_inc = {1'b0, mant_r} + {24'd0, round_up};
        exp_fin  = exp_r;
        frac_fin = mant_inc[22:0];
        if (mant_inc[24]) begin
            exp_fin  = exp_r + 10'sd1;
            frac_fin = mant_inc[23:1];
        end
        rnd_flags = '0;
        if (exp_fin >= 10'sd255) begin
            rnd_result = INF | {sign_c, 31'd0};
            rnd_flags[FLAG_OVERFLOW] = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            rnd_result = {sign_c, 31'd0};
            rnd_flags[FLAG_UNDERFLOW] = 1'b1;
        end else begin
            rnd_result = {sign_c, exp_fin[7:0], frac_fin};
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            ready_out <= 1'b0;
            result    <= '0;
            exc_flags <= '0;
            a_r       <= '0;
            b_r       <= '0;
            exp_r     <= '0;
            rem_r     <= '0;
            q_r       <= '0;
            cnt       <= '0;
            mant_r    <= '0;
            special_r <= 1'b0;
        end else begin
            ready_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= a_in;
                        b_r   <= b_in;
                        busy  <= 1'b1;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    exp_r     <= exp_calc;
                    rem_r     <= {2'b01, ua.frac};
                    q_r       <= '0;
                    cnt       <= '0;
                    special_r <= is_special;
                    state     <= is_special ? S_ROUND : S_DIVIDE;
                end
                S_DIVIDE: begin
                    q_r   <= {q_r[QBITS-2:0], q_bit};
                    rem_r <= next_rem;
                    cnt   <= cnt + 8'd1;
                    if (cnt == 8'(QBITS - 1)) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    mant_r <= norm_mant;
                    exp_r  <= q_r[QBITS-1] ? exp_r : (exp_r - 10'sd1);
                    state  <= S_ROUND;
                end
                S_ROUND: begin
                    result    <= special_r ? spec_result : rnd_result;
                    exc_flags <= special_r ? spec_flags : rnd_flags;
                    ready_out <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_fpu_div.sv
// Self-checking bench for ieee_fpu_div: integer-arithmetic reference model,
// directed special/boundary cases, abort-by-reset and random operands.
module tb_ieee_fpu_div;

`ifdef FPU_DIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif
    localparam logic [31:0] ONE_THIRD = RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA;

    logic        clk, rst, start;
    logic [31:0] a_in, b_in, result;
    logic        busy, ready_out;
    logic [3:0]  exc_flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;
    logic [3:0]  last_flags = '0;
    logic [31:0] specials [7];

    ieee_fpu_div dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .ready_out (ready_out),
        .result    (result),
        .exc_flags (exc_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer quotient of the 24-bit significands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        int ea, eb, e;
        logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
        logic [63:0] num, den, quo, rm, m;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s = a[31] ^ b[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        b_inf = (eb == 255) && (b[22:0] == 0);
        a_nan = (ea == 255) && (a[22:0] != 0);
        b_nan = (eb == 255) && (b[22:0] != 0);
        f = 4'b0000;
        lat = 2;
        r = '0;
        if (a_nan || b_nan) r = 32'h7FC00000;
        else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            r = 32'h7FC00000; f = 4'b1000;
        end else if (b_zero && !a_inf) begin
            r = {s, 8'hFF, 23'd0}; f = 4'b0100;
        end else if (a_inf) r = {s, 8'hFF, 23'd0};
        else if (a_zero || b_inf) r = {s, 31'd0};
        else begin
            lat = 29;
            num = {40'd0, 1'b1, a[22:0]} << 26;
            den = {40'd0, 1'b1, b[22:0]};
            quo = num / den;
            rm  = num % den;
            e = ea - eb + 127;
            if (quo[26]) begin
                m = quo >> 3; g = quo[2]; st = (quo[1:0] != 0) || (rm != 0);
            end else begin
                m = quo >> 2; g = quo[1]; st = quo[0] || (rm != 0); e = e - 1;
            end
            if (RNE && g && (st || m[0])) m = m + 1;
            if (m[24]) begin m = m >> 1; e = e + 1; end
            if (e >= 255) begin r = {s, 8'hFF, 23'd0}; f = 4'b0010; end
            else if (e <= 0) begin r = {s, 31'd0}; f = 4'b0001; end
            else r = {s, 8'(e), m[22:0]};
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: v = specials[$urandom_range(0, 6)];
            1: v = $urandom;
            2: v = {1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 10)) : 8'($urandom_range(245, 254)),
                    23'($urandom)};
            default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
        endcase
        return v;
    endfunction

    // Compare process: every cycle out of reset, check completion, hold and busy.
    always @(negedge clk) begin : compare
        exp_t e;
        logic exp_busy;
        if (!rst) begin
            if (ready_out) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: ready_out=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("flags", {28'd0, exc_flags}, {28'd0, e.flags});
                    chk("latency", 32'(cyc - e.issue - 1), 32'(e.lat));
                    last_res   = e.res;
                    last_flags = e.flags;
                end
            end else begin
                chk("hold_result", result, last_res);
                chk("hold_flags", {28'd0, exc_flags}, {28'd0, last_flags});
            end
            exp_busy = (exp_q.size() != 0) ? (cyc > exp_q[0].issue) : 1'b0;
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL timeout: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        @(posedge clk);
        #1;
        model(a, b, e.res, e.flags, e.lat);
        e.issue = cyc;
        exp_q.push_back(e);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    task automatic pin(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input int el);
        logic [31:0] r;
        logic [3:0]  f;
        int          l;
        model(a, b, r, f, l);
        chk("pin_result", r, er);
        chk("pin_flags", {28'd0, f}, {28'd0, ef});
        chk("pin_latency", 32'(l), 32'(el));
        run_op(a, b);
    endtask

    initial begin
        specials[0] = 32'h00000000;
        specials[1] = 32'h80000000;
        specials[2] = 32'h7F800000;
        specials[3] = 32'hFF800000;
        specials[4] = 32'h7FC00000;
        specials[5] = 32'h7F800001;
        specials[6] = 32'h00000123;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_result", result, 32'h0);
        chk("reset_flags", {28'd0, exc_flags}, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        chk("reset_ready", {31'd0, ready_out}, 32'h0);

        pin(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29);
        pin(32'h3F800000, 32'h40400000, ONE_THIRD,    4'b0000, 29);
        pin(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 2);
        pin(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);
        pin(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 2);
        pin(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 29);
        pin(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 29);
        pin(32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 29);
        pin(32'h00800000, 32'h3FC00000, 32'h00000000, 4'b0001, 29);
        pin(32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000, 2);
        pin(32'hFF800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2);
        pin(32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 2);

        // start while busy must be ignored
        run_op(32'h3F800000, 32'h40400000);
        repeat (5) @(posedge clk);
        #1 start = 1'b1; a_in = 32'h40C00000; b_in = 32'h40000000;
        @(posedge clk);
        #1 start = 1'b0;

        // reset in DIVIDE cycle 10 aborts; then a clean operation
        run_op(32'h3F800000, 32'h40400000);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        last_res = '0;
        last_flags = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_result", result, 32'h0);
        chk("abort_flags", {28'd0, exc_flags}, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        chk("abort_ready", {31'd0, ready_out}, 32'h0);
        repeat (40) @(posedge clk);
        run_op(32'h40C00000, 32'h40000000);

        for (int i = 0; i < 60; i++) begin
            run_op(rand_operand(), rand_operand());
        end
        wait_idle();
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
